strobe_meter: RTL and testbench

Receive-side companion to the strobe generator: watches a periodic single-cycle strobe and measures its period in `clk` cycles. It reports when the strobe is stable (locked), when the period slips, and when the strobe disappears. It sits on sample-rate strobe nets, for example between the rate divider and the interpolator/modulator chain, as a rate monitor and lock indicator.

---
 rtl/strobe_meter.sv | 172 +++++++++++++++++
 tb/tb_strobe_meter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_meter.sv
// strobe_meter: measures the period of a single-cycle strobe and reports lock, slip and timeout.
// Define STROBE_METER_AVG_EN to report the mean of the last four intervals instead of the raw one.
module strobe_meter #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             stb_in,
  output logic [WIDTH-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             slip,
  output logic             missing,
  output logic [1:0]       dbg_state
);

  // period is qualified by period_vld: a one-cycle pulse per measured strobe, no backpressure.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] GAP_MAX   = {WIDTH{1'b1}};
  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [WIDTH:0]   TOL_W     = (WIDTH+1)'(TOL);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gap_q, gap_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [3:0]       match_q, match_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             slip_q, slip_d;
  logic             missing_q, missing_d;
  logic             meas;
  logic             first;

  logic [WIDTH:0] diff;
  logic [WIDTH:0] abs_diff;
  logic           in_tol;

  assign diff     = {1'b0, gap_q} - {1'b0, ref_q};
  assign abs_diff = diff[WIDTH] ? (~diff + 1'b1) : diff;
  assign in_tol   = (abs_diff <= TOL_W);

`ifdef STROBE_METER_AVG_EN
  logic [WIDTH-1:0] hist_q [4];
  logic [WIDTH-1:0] hist_d [4];
  logic [WIDTH+1:0] sum_v;
`endif

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    ref_d     = ref_q;
    match_d   = match_q;
    vld_d     = 1'b0;
    slip_d    = 1'b0;
    missing_d = 1'b0;
    meas      = 1'b0;
    first     = 1'b0;
    if (enable) begin
      if (stb_in) begin
        gap_d = WIDTH'(1);
      end else if (gap_q != GAP_MAX) begin
        gap_d = gap_q + 1'b1;
      end
      if (stb_in) begin
        case (state_q)
          IDLE: state_d = MEASURE;
          MEASURE: begin
            ref_d   = gap_q;
            match_d = 4'd0;
            meas    = 1'b1;
            first   = 1'b1;
            state_d = TRACK;
          end
          TRACK: begin
            meas = 1'b1;
            if (in_tol) begin
              if (match_q == LOCK_LAST) state_d = LOCKED;
              else                      match_d = match_q + 1'b1;
            end else begin
              ref_d   = gap_q;
              match_d = 4'd0;
            end
          end
          default: begin
            meas = 1'b1;
            // Reference is frozen while locked, so slow drift eventually slips.
            if (!in_tol) begin
              slip_d  = 1'b1;
              ref_d   = gap_q;
              match_d = 4'd0;
              state_d = TRACK;
            end
          end
        endcase
      end else if (gap_q == GAP_MAX && state_q != IDLE) begin
        missing_d = 1'b1;
        match_d   = 4'd0;
        state_d   = IDLE;
      end
    end
    vld_d = meas;
  end

`ifdef STROBE_METER_AVG_EN
  always_comb begin
    for (int i = 0; i < 4; i++) hist_d[i] = hist_q[i];
    if (meas) begin
      if (first) begin
        for (int i = 0; i < 4; i++) hist_d[i] = gap_q;
      end else begin
        hist_d[0] = gap_q;
        hist_d[1] = hist_q[0];
        hist_d[2] = hist_q[1];
        hist_d[3] = hist_q[2];
      end
    end
    sum_v = {2'b00, hist_d[0]} + {2'b00, hist_d[1]} + {2'b00, hist_d[2]} + {2'b00, hist_d[3]};
    period_d = meas ? sum_v[WIDTH+1:2] : period_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
    end
  end
`else
  always_comb begin
    period_d = meas ? gap_q : period_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      ref_q     <= '0;
      match_q   <= 4'd0;
      period_q  <= '0;
      vld_q     <= 1'b0;
      slip_q    <= 1'b0;
      missing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      ref_q     <= ref_d;
      match_q   <= match_d;
      period_q  <= period_d;
      vld_q     <= vld_d;
      slip_q    <= slip_d;
      missing_q <= missing_d;
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign locked     = (state_q == LOCKED);
  assign slip       = slip_q;
  assign missing    = missing_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_strobe_meter.sv
// Directed bench for strobe_meter: vector table for lock/tolerance/slip plus timeout, enable, reset and averaging sequences.
module tb_strobe_meter;
  localparam int W = 8;

  typedef struct {
    int         n;
    logic       vld;
    logic [W-1:0] per;
    logic       lk;
    logic       slp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         stb_in;
  logic [W-1:0] period;
  logic         period_vld;
  logic         locked;
  logic         slip;
  logic         missing;
  logic [1:0]   dbg_state;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];
  vec_t         vq[$];

  strobe_meter #(.WIDTH(W), .LOCK_COUNT(4), .TOL(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .stb_in     (stb_in),
    .period     (period),
    .period_vld (period_vld),
    .locked     (locked),
    .slip       (slip),
    .missing    (missing),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; enable = 1'b1; stb_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // driver: n-1 quiet cycles then a one-cycle strobe, so the DUT sees interval n
  task automatic send(int n, logic ev, logic [W-1:0] ep);
    logic spur;
    spur = 1'b0;
    stb_in = 1'b0;
    for (int i = 1; i < n; i++) begin
      tick();
      if (slip || missing) spur = 1'b1;
    end
    if (ev) exp_q.push_back(ep);
    stb_in = 1'b1;
    tick();
    stb_in = 1'b0;
    check("quiet_pulse", {31'd0, spur}, 32'd0);
  endtask

  task automatic add(int n, logic v, logic [W-1:0] p, logic l, logic s);
    vec_t e;
    e.n = n; e.vld = v; e.per = p; e.lk = l; e.slp = s;
    vq.push_back(e);
  endtask

  // scoreboard: every period_vld pulse must match the next expected period
  always @(posedge clk) begin
    #1;
    if (!rst && period_vld) begin
      if (exp_q.size() == 0) check("unexpected_vld", {31'd0, period_vld}, 32'd0);
      else                   check("sb_period", {24'd0, period}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int miss_cnt;
    int miss_at;
    logic spur;
    int avg_n [4];
    logic [W-1:0] avg_exp [4];

    add(3, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(5, 1, 5, 0, 0);
    add(5, 1, 5, 1, 0);
    add(6, 1, 6, 1, 0);
    add(8, 1, 8, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 0);
    add(1, 1, 1, 1, 0);
    add(2, 1, 2, 1, 0);
    add(10, 1, 10, 0, 1);
    for (int i = 0; i < 3; i++) add(10, 1, 10, 0, 0);
    add(10, 1, 10, 1, 0);

    reset_dut();
    check("rst_period", {24'd0, period}, 32'd0);
    check("rst_vld", {31'd0, period_vld}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_slip", {31'd0, slip}, 32'd0);
    check("rst_missing", {31'd0, missing}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    foreach (vq[k]) begin
      send(vq[k].n, vq[k].vld, vq[k].per);
      check($sformatf("v%0d_vld", k), {31'd0, period_vld}, {31'd0, vq[k].vld});
      check($sformatf("v%0d_period", k), {24'd0, period}, {24'd0, vq[k].per});
      check($sformatf("v%0d_locked", k), {31'd0, locked}, {31'd0, vq[k].lk});
      check($sformatf("v%0d_slip", k), {31'd0, slip}, {31'd0, vq[k].slp});
      check($sformatf("v%0d_missing", k), {31'd0, missing}, 32'd0);
    end

    // timeout from lock at 10
    miss_cnt = 0; miss_at = 0; spur = 1'b0;
    stb_in = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (missing) begin
        miss_cnt++;
        if (miss_at == 0) miss_at = i;
      end
      if (slip && missing) spur = 1'b1;
    end
    check("to_miss_cnt", miss_cnt, 1);
    check("to_miss_at", miss_at, 255);
    check("to_slip_and_miss", {31'd0, spur}, 32'd0);
    check("to_locked", {31'd0, locked}, 32'd0);
    check("to_state", {30'd0, dbg_state}, 32'd0);
    send(5, 0, 0);
    check("to_next_vld", {31'd0, period_vld}, 32'd0);
    send(255, 1, 255);
    check("max_period", {24'd0, period}, 32'd255);
    check("max_missing", {31'd0, missing}, 32'd0);
    send(255, 1, 255);
    check("max2_period", {24'd0, period}, 32'd255);
    check("max2_locked", {31'd0, locked}, 32'd0);

    // strobe every cycle from reset
    reset_dut();
    send(1, 0, 0);
    for (int i = 0; i < 4; i++) send(1, 1, 1);
    check("c1_locked5", {31'd0, locked}, 32'd0);
    send(1, 1, 1);
    check("c1_locked6", {31'd0, locked}, 32'd1);
    check("c1_period", {24'd0, period}, 32'd1);

    // enable freeze mid-interval at period 7
    reset_dut();
    send(3, 0, 0);
    for (int i = 0; i < 5; i++) send(7, 1, 7);
    check("en_locked_pre", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b0;
    spur = 1'b0;
    for (int i = 0; i < 20; i++) begin
      stb_in = (i == 5 || i == 6);
      tick();
      if (period_vld || slip || missing) spur = 1'b1;
    end
    stb_in = 1'b0;
    enable = 1'b1;
    check("en_frozen_pulse", {31'd0, spur}, 32'd0);
    check("en_frozen_locked", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    exp_q.push_back(8'd7);
    stb_in = 1'b1;
    tick();
    stb_in = 1'b0;
    check("en_vld", {31'd0, period_vld}, 32'd1);
    check("en_period", {24'd0, period}, 32'd7);
    check("en_locked", {31'd0, locked}, 32'd1);
    check("en_slip", {31'd0, slip}, 32'd0);

    // reset while locked, with a strobe present
    rst = 1'b1; stb_in = 1'b1; enable = 1'b1;
    tick();
    check("mr_period", {24'd0, period}, 32'd0);
    check("mr_vld", {31'd0, period_vld}, 32'd0);
    check("mr_locked", {31'd0, locked}, 32'd0);
    check("mr_slip", {31'd0, slip}, 32'd0);
    check("mr_missing", {31'd0, missing}, 32'd0);
    check("mr_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0; stb_in = 1'b0;

    // reported period for intervals 4,4,4,8
    avg_n = '{4, 4, 4, 8};
`ifdef STROBE_METER_AVG_EN
    avg_exp = '{8'd4, 8'd4, 8'd4, 8'd5};
`else
    avg_exp = '{8'd4, 8'd4, 8'd4, 8'd8};
`endif
    reset_dut();
    send(3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      send(avg_n[i], 1, avg_exp[i]);
      check($sformatf("avg%0d_period", i), {24'd0, period}, {24'd0, avg_exp[i]});
    end

    tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
